// File: rtl/axil_cmd_master.sv
// axil_cmd_master: turns one command at a time into an AXI-Lite read or write. A failed
// response (resp[0] = 0) re-issues the same transfer up to MAX_RETRY times. The final
// result is then reported on the rsp_* channel.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake; cmd_ready is high only in IDLE
//   cmd_write/addr/wdata        command fields, registered on acceptance
//   rsp_valid/rsp_ready         result handshake (RSP state)
//   rsp_rdata/rsp_ok/retries    result: last read data (0 for writes), success, re-issues used
//   busy                        high whenever not IDLE
//   ar_*, r_*, aw_*, w_*, b_*   AXI-Lite master channels, one transfer outstanding at most
module axil_cmd_master #(
  parameter int unsigned ADDR_WDTH = 4,
  parameter int unsigned DATA_WDTH = 32,
  parameter int unsigned RESP_WDTH = 1,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ADDR_WDTH-1:0] cmd_addr,
  input  logic [DATA_WDTH-1:0] cmd_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_WDTH-1:0] rsp_rdata,
  output logic                 rsp_ok,
  output logic [2:0]           rsp_retries,
  output logic                 busy,
  output logic                 ar_valid,
  input  logic                 ar_ready,
  output logic [ADDR_WDTH-1:0] ar_address,
  input  logic                 r_valid,
  output logic                 r_ready,
  input  logic [DATA_WDTH-1:0] r_data,
  input  logic [RESP_WDTH-1:0] r_resp,
  output logic                 aw_valid,
  input  logic                 aw_ready,
  output logic [ADDR_WDTH-1:0] aw_address,
  output logic                 w_valid,
  input  logic                 w_ready,
  output logic [DATA_WDTH-1:0] w_data,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [RESP_WDTH-1:0] b_resp
);

  localparam logic [2:0] MaxRetry = 3'(MAX_RETRY);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StAr   = 3'd1,
    StR    = 3'd2,
    StAw   = 3'd3,
    StW    = 3'd4,
    StB    = 3'd5,
    StRsp  = 3'd6
  } state_e;

  state_e                 state_q;
  logic                   write_q;
  logic [ADDR_WDTH-1:0]   addr_q;
  logic [DATA_WDTH-1:0]   wdata_q;
  logic [DATA_WDTH-1:0]   rdata_q;
  logic                   ok_q;
  logic [2:0]             retry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ok_q    <= 1'b0;
      retry_q <= 3'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            write_q <= cmd_write;
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            // rdata stays 0 for writes, so clear it for every new command
            rdata_q <= '0;
            ok_q    <= 1'b0;
            retry_q <= 3'd0;
            state_q <= cmd_write ? StAw : StAr;
          end
        end
        StAr: if (ar_ready) state_q <= StR;
        StR: begin
          if (r_valid) begin
            rdata_q <= r_data;
            if (r_resp[0]) begin
              ok_q    <= 1'b1;
              state_q <= StRsp;
            end else if (retry_q < MaxRetry) begin
              retry_q <= retry_q + 3'd1;
              state_q <= StAr;
            end else begin
              ok_q    <= 1'b0;
              state_q <= StRsp;
            end
          end
        end
        StAw: if (aw_ready) state_q <= StW;
        StW:  if (w_ready) state_q <= StB;
        StB: begin
          if (b_valid) begin
            if (b_resp[0]) begin
              ok_q    <= 1'b1;
              state_q <= StRsp;
            end else if (retry_q < MaxRetry) begin
              retry_q <= retry_q + 3'd1;
              state_q <= StAw;
            end else begin
              ok_q    <= 1'b0;
              state_q <= StRsp;
            end
          end
        end
        StRsp: if (rsp_ready) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // write_q is kept for visibility of the command type; retries re-enter AR/AW directly
  logic unused_write;
  assign unused_write = write_q;

  // All handshake outputs are plain decodes of the state register.
  assign cmd_ready   = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign ar_valid    = (state_q == StAr);
  assign r_ready     = (state_q == StR);
  assign aw_valid    = (state_q == StAw);
  assign w_valid     = (state_q == StW);
  assign b_ready     = (state_q == StB);
  assign rsp_valid   = (state_q == StRsp);
  assign ar_address  = addr_q;
  assign aw_address  = addr_q;
  assign w_data      = wdata_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_ok      = ok_q;
  assign rsp_retries = retry_q;

endmodule

// File: doc/axil_cmd_master.md
AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

Interface
REQ-001 Parameter ADDR_WDTH, default 4, AXI-Lite address width.
REQ-002 Parameter DATA_WDTH, default 32, data width.
REQ-003 Parameter RESP_WDTH, default 1, response width; value 1 = OKAY, 0 = error.
REQ-004 Parameter MAX_RETRY, default 3, maximum re-issues of a failed transaction; range 0-7.
REQ-005 Ports, in order: name, direction, width, meaning.
- clk, in, 1, clock. Reset rst_n, asynchronous, active-low; clock clk.
- rst_n, in, 1, asynchronous active-low reset.
- cmd_valid, in, 1, command offered.
- cmd_ready, out, 1, command accepted this cycle when cmd_valid is also high.
- cmd_write, in, 1, 1 = write, 0 = read.
- cmd_addr, in, ADDR_WDTH, target address.
- cmd_wdata, in, DATA_WDTH, write data.
- rsp_valid, out, 1, result available.
- rsp_ready, in, 1, result consumed.
- rsp_rdata, out, DATA_WDTH, read data; 0 for writes.
- rsp_ok, out, 1, final transaction succeeded.
- rsp_retries, out, 3, number of re-issues used.
- busy, out, 1, high in every state except IDLE.
- ar_valid/ar_ready/ar_address, out/in/out, 1/1/ADDR_WDTH, read address channel.
- r_valid/r_ready/r_data/r_resp, in/out/in/in, 1/1/DATA_WDTH/RESP_WDTH, read data channel.
- aw_valid/aw_ready/aw_address, out/in/out, 1/1/ADDR_WDTH, write address channel.
- w_valid/w_ready/w_data, out/in/out, 1/1/DATA_WDTH, write data channel.
- b_valid/b_ready/b_resp, in/out/in, 1/1/RESP_WDTH, write response channel.

Function
REQ-006 The FSM SHALL have seven states: IDLE, AR, R, AW, W, B, RSP.
REQ-007 cmd_ready SHALL equal (state == IDLE); on cmd_valid & cmd_ready, the block SHALL register cmd_write, cmd_addr and cmd_wdata, clear the retry counter, and move to AR (read) or AW (write).
REQ-008 ar_valid SHALL be high only in AR, and aw_valid only in AW. Both SHALL be registered-state decodes and SHALL stay high, with the address stable, until the matching ready is sampled high.
REQ-009 AR SHALL go to R on ar_ready. AW SHALL go to W on aw_ready. Write data SHALL NOT be issued before the AW handshake completes.
REQ-010 w_valid SHALL be high only in W, with w_data equal to the registered data. W SHALL go to B on w_ready.
REQ-011 r_ready SHALL be high throughout R. On r_valid, the block SHALL capture r_data and r_resp.
REQ-012 b_ready SHALL be high throughout B. On b_valid, the block SHALL capture b_resp.
REQ-013 Resolution of a captured response (ok = resp[0]):
- ok = 1: go to RSP with rsp_ok = 1.
- ok = 0 and retry count < MAX_RETRY: increment the count and return to AR (read) or AW (write), using the same address and data.
- ok = 0 and retry count == MAX_RETRY: go to RSP with rsp_ok = 0.
REQ-014 In RSP, rsp_valid SHALL be high and rsp_rdata/rsp_ok/rsp_retries SHALL be held stable until rsp_ready; then the FSM SHALL go to IDLE.
REQ-015 rsp_rdata SHALL hold the last captured r_data for reads (including a failed final attempt) and 0 for writes.
REQ-016 An undefined state encoding SHALL go to IDLE on the next clock.
REQ-017 Every AXI channel SHALL carry at most one outstanding transaction, and no new command SHALL be accepted until RSP completes.
REQ-018 Minimum command-to-rsp_valid latency SHALL be 3 cycles for a read and 4 cycles for a write, with zero-wait slave readies.

Reset
REQ-019 While rst_n = 0, state SHALL be IDLE and all registers 0. Consequently cmd_ready = 1, and busy, all *_valid, r_ready, b_ready, rsp_valid and rsp_ok SHALL be 0.
REQ-020 Reset asserted mid-transaction SHALL abort the transaction immediately, with no response generated. After release, the block SHALL accept a new command.

Verification
REQ-021 Read, slave OKAY: cmd read addr 0x5, slave returns 0xDEADBEEF with resp 1 -> one AR with address 0x5; rsp_valid with rdata 0xDEADBEEF, ok 1, retries 0.
REQ-022 Write, slave OKAY: cmd write addr 0xA, data 0x12345678 -> AW address 0xA before w_valid; w_data 0x12345678; rsp ok 1, rdata 0.
REQ-023 Retry success: read where the first two r_resp are 0 and the third is 1 -> exactly 3 AR handshakes to the same address; rsp ok 1, retries 2.
REQ-024 Retry exhaustion: write with b_resp always 0, MAX_RETRY = 3 -> 4 AW/W pairs; rsp ok 0, retries 3.
REQ-025 Backpressure: ar_ready low for 5 cycles, then rsp_ready low for 4 cycles -> ar_valid/address held steady; rsp outputs stable; cmd_ready stays 0 until the rsp handshake completes.
REQ-026 Reset mid-W: rst_n pulsed low while w_valid = 1 -> all valids drop asynchronously; no rsp_valid; the next read command completes normally.
